mc_control: RTL and testbench
=============================

# mc_control

Multicycle main control unit for the MIPS-lite datapath: the producer side of the ALUOp interface, driving `aluop1`/`aluop0` and every other datapath enable from a Moore state machine sequenced by the instruction opcode. It sits between the instruction register and the multicycle datapath, feeding the existing ALU control decoder (`aluop` 00 = add, 01 = subtract, 10 = funct-decoded). It also stalls on a memory ready handshake and counts retired instructions.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; forces FETCH and clears counters.
- `opcode`  in  6  IR[31:26]; sampled only in DECODE.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `memtoreg`, `irwrite`, `regwrite`, `regdst`, `alusrca`  out  1 each  datapath enables/selects.
- `alusrcb`  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- `pcsource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluop1`, `aluop0`  out  1 each  to ALU control.
- `illegal_op`  out  1  one-cycle pulse in DECODE on an unsupported opcode.
- `instr_count`  out  32  retired-instruction count.
- `state`  out  4  current state, for debug/verification.

## Operation
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010. All others are illegal.
- States (4-bit): 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 RCOMP, 8 BRANCH, 9 JUMP. Encodings 10–15 are unreachable; if entered, go to FETCH next cycle with all outputs 0.
- Transitions:
  - FETCH goes to DECODE when `mem_ready`, otherwise holds.
  - DECODE goes to MEMADR (LW/SW), EXEC (R), BRANCH (BEQ), JUMP (J), or FETCH (illegal).
  - MEMADR goes to MEMRD (LW) or MEMWR (SW). `opcode` is held stable by the IR.
  - MEMRD goes to MEMWB when `mem_ready`, otherwise holds.
  - MEMWR goes to FETCH when `mem_ready`, otherwise holds.
  - EXEC goes to RCOMP.
  - MEMWB, RCOMP, BRANCH and JUMP go to FETCH.
- Outputs are 0 unless listed:
  - FETCH: `memread`=1, `alusrcb`=01, `pcsource`=00; `irwrite`=`pcwrite`=`mem_ready` (the only Mealy terms).
  - DECODE: `alusrcb`=11, `aluop`=00.
  - MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=00.
  - MEMRD: `memread`=1, `iord`=1.
  - MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0.
  - MEMWR: `memwrite`=1, `iord`=1.
  - EXEC: `alusrca`=1, `alusrcb`=00, `aluop`=10.
  - RCOMP: `regwrite`=1, `regdst`=1.
  - BRANCH: `alusrca`=1, `aluop`=01, `pcwritecond`=1, `pcsource`=01.
  - JUMP: `pcwrite`=1, `pcsource`=10.
- Retirement: `instr_count` increments by 1 on the clock edge leaving MEMWB, RCOMP, BRANCH or JUMP, and leaving MEMWR with `mem_ready`=1. It wraps from 0xFFFFFFFF to 0. Illegal opcodes do not retire.

## Timing
- Reset, while asserted and after release: `state`=FETCH, `instr_count`=0.
  - Outputs take their FETCH values: `memread`=1, `alusrcb`=01; `irwrite`/`pcwrite` follow `mem_ready`.
  - The bench must hold `mem_ready`=0 during reset.
- Reset asserted mid-instruction aborts it immediately, with no retirement count.
- Zero-wait-state latency in cycles: LW 5, SW 4, R 4, BEQ 3, J 3, illegal 2.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- `mem_ready` is ignored in all other states.
- Moore outputs change only after a clock edge. The FETCH Mealy terms may change combinationally with `mem_ready`.

## Structure
- Shared package `mips_lite_pkg`:
  - state encoding constants;
  - opcode constants (shared with the single-cycle control);
  - ALUOp constants (ADD=00, SUB=01, FUNCT=10);
  - `alusrcb`/`pcsource` select encodings.
- No sub-module. Use one registered state process, one next-state block, one output decode block and the counter.

## Test plan
- Reset with `mem_ready`=1, then LW: `state` sequence 0,1,2,3,4,0 over 5 cycles; `regwrite`=`memtoreg`=1 only in state 4; `instr_count`=1.
- R-type (opcode 0): EXEC has `aluop1`=1, `aluop0`=0; RCOMP has `regwrite`=`regdst`=1; 4 cycles; `instr_count` +1.
- SW with `mem_ready` low for 3 cycles in MEMWR: `memwrite` held 4 cycles; no count until the ready cycle; 7 cycles total.
- BEQ then J: BRANCH has `aluop`=01, `pcwritecond`=1, `pcsource`=01; JUMP has `pcwrite`=1, `pcsource`=10; `instr_count` +2.
- Opcode 0x3F: `illegal_op` pulses one cycle in DECODE; returns to FETCH; `instr_count` unchanged.
- Reset asserted in MEMRD: `state` is 0 asynchronously; preload `instr_count`=0xFFFFFFFF via 2^32−1 retirements (or force), then one J retires: wraps to 0.

Source files
------------

// File: rtl/mips_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_lite_pkg
//  Description : Shared encodings for the MIPS-lite control path: multicycle
//                state numbers, primary opcodes, ALUOp codes and the
//                datapath mux select encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_lite_pkg;

   // Multicycle controller state encoding (also exported on the debug port)
   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_RCOMP  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_JUMP   = 4'd9;

   // Primary opcodes, IR[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALUOp codes understood by the ALU control decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU B-operand select
   localparam logic [1:0] ALUSRCB_B       = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
   localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // True for the opcodes this datapath implements
   function automatic logic op_is_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_J);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control
//  Description : Multicycle main control unit for the MIPS-lite datapath.
//                Moore FSM sequenced by the opcode, stalling on mem_ready in
//                the memory-access states, plus a retired-instruction counter.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk          in   1   rising-edge clock
//    reset        in   1   asynchronous active-high; forces FETCH, clears count
//    opcode       in   6   IR[31:26]
//    mem_ready    in   1   memory completes current access this cycle
//    pcwrite .. alusrca  out 1 each  datapath enables / selects
//    alusrcb      out  2   ALU B select
//    pcsource     out  2   PC source select
//    aluop1/0     out  1   ALUOp to ALU control
//    illegal_op   out  1   pulse in DECODE on an unsupported opcode
//    instr_count  out  32  retired-instruction count (wraps)
//    state        out  4   current state (debug)
// ============================================================================
module mc_control
   import mips_lite_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic        mem_ready,
   output logic        pcwrite,
   output logic        pcwritecond,
   output logic        iord,
   output logic        memread,
   output logic        memwrite,
   output logic        memtoreg,
   output logic        irwrite,
   output logic        regwrite,
   output logic        regdst,
   output logic        alusrca,
   output logic [1:0]  alusrcb,
   output logic [1:0]  pcsource,
   output logic        aluop1,
   output logic        aluop0,
   output logic        illegal_op,
   output logic [31:0] instr_count,
   output logic [3:0]  state
);

   logic [3:0]  state_q;
   logic [3:0]  state_d;
   logic [31:0] count_q;
   logic [31:0] count_d;
   logic [1:0]  aluop_sel;
   logic        retire;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         // Only LW or SW can reach MEMADR; the IR holds the opcode stable.
         S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWR: begin
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXEC:   state_d = S_RCOMP;
         S_MEMWB,
         S_RCOMP,
         S_BRANCH,
         S_JUMP:   state_d = S_FETCH;
         // Unused encodings recover to FETCH
         default:  state_d = S_FETCH;
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode. Everything is Moore except the FETCH irwrite/pcwrite
   // terms, which must follow mem_ready in the same cycle so the IR and PC
   // capture on the edge that completes the instruction fetch.
   // ------------------------------------------------------------------
   always_comb begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      memtoreg    = 1'b0;
      irwrite     = 1'b0;
      regwrite    = 1'b0;
      regdst      = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = ALUSRCB_B;
      pcsource    = PCSRC_ALU;
      aluop_sel   = ALUOP_ADD;
      illegal_op  = 1'b0;
      case (state_q)
         S_FETCH: begin
            memread  = 1'b1;
            alusrcb  = ALUSRCB_FOUR;
            pcsource = PCSRC_ALU;
            irwrite  = mem_ready;
            pcwrite  = mem_ready;
         end
         S_DECODE: begin
            alusrcb    = ALUSRCB_IMM_SH2;
            aluop_sel  = ALUOP_ADD;
            illegal_op = ~op_is_legal(opcode);
         end
         S_MEMADR: begin
            alusrca   = 1'b1;
            alusrcb   = ALUSRCB_IMM;
            aluop_sel = ALUOP_ADD;
         end
         S_MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
         end
         S_EXEC: begin
            alusrca   = 1'b1;
            alusrcb   = ALUSRCB_B;
            aluop_sel = ALUOP_FUNCT;
         end
         S_RCOMP: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         S_BRANCH: begin
            alusrca     = 1'b1;
            aluop_sel   = ALUOP_SUB;
            pcwritecond = 1'b1;
            pcsource    = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            pcwrite  = 1'b1;
            pcsource = PCSRC_JUMP;
         end
         default: begin
            // unreachable encodings: all outputs stay 0
         end
      endcase
   end

   assign aluop1 = aluop_sel[1];
   assign aluop0 = aluop_sel[0];

   // ------------------------------------------------------------------
   // Retired-instruction counter: an instruction retires on the edge that
   // leaves its final state. Illegal opcodes never reach one of these.
   // ------------------------------------------------------------------
   assign retire = (state_q == S_MEMWB)  || (state_q == S_RCOMP) ||
                   (state_q == S_BRANCH) || (state_q == S_JUMP)  ||
                   ((state_q == S_MEMWR) && mem_ready);

   assign count_d = retire ? (count_q + 32'd1) : count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= 32'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign instr_count = count_q;
   assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_control
//  Description : Self-checking bench for mc_control. Each instruction is
//                expanded into its expected per-cycle phase list (with random
//                memory wait cycles) and every cycle's state, outputs and
//                retired count are compared against that expectation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_control;

   localparam logic [5:0] C_LW   = 6'b100011;
   localparam logic [5:0] C_SW   = 6'b101011;
   localparam logic [5:0] C_R    = 6'b000000;
   localparam logic [5:0] C_BEQ  = 6'b000100;
   localparam logic [5:0] C_J    = 6'b000010;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic        pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
   logic        irwrite, regwrite, regdst, alusrca;
   logic [1:0]  alusrcb, pcsource;
   logic        aluop1, aluop0, illegal_op;
   logic [31:0] instr_count;
   logic [3:0]  state;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_count;

   mc_control dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .mem_ready   (mem_ready),
      .pcwrite     (pcwrite),
      .pcwritecond (pcwritecond),
      .iord        (iord),
      .memread     (memread),
      .memwrite    (memwrite),
      .memtoreg    (memtoreg),
      .irwrite     (irwrite),
      .regwrite    (regwrite),
      .regdst      (regdst),
      .alusrca     (alusrca),
      .alusrcb     (alusrcb),
      .pcsource    (pcsource),
      .aluop1      (aluop1),
      .aluop0      (aluop0),
      .illegal_op  (illegal_op),
      .instr_count (instr_count),
      .state       (state)
   );

   always #5 clk = ~clk;

   // {pcwrite,pcwritecond,iord,memread,memwrite,memtoreg,irwrite,regwrite,
   //  regdst,alusrca,alusrcb[1:0],pcsource[1:0],aluop1,aluop0,illegal_op}
   logic [16:0] w_act;
   assign w_act = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
                   irwrite, regwrite, regdst, alusrca, alusrcb, pcsource,
                   aluop1, aluop0, illegal_op};

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)",
                  tag, obs, exp, $time);
      end
   endtask

   function automatic logic is_legal(input logic [5:0] op);
      return op inside {C_LW, C_SW, C_R, C_BEQ, C_J};
   endfunction

   // Output table by phase number.
   function automatic logic [16:0] exp_outs(input int ph, input logic rdy,
                                            input logic [5:0] op);
      logic pw, pwc, io, mr, mw, m2r, irw, rw, rd, sa, a1, a0, ill;
      logic [1:0] sb, ps;
      {pw, pwc, io, mr, mw, m2r, irw, rw, rd, sa, a1, a0, ill} = '0;
      sb = 2'b00;
      ps = 2'b00;
      case (ph)
         0: begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
         1: begin sb = 2'b11; ill = !is_legal(op); end
         2: begin sa = 1; sb = 2'b10; end
         3: begin mr = 1; io = 1; end
         4: begin rw = 1; m2r = 1; end
         5: begin mw = 1; io = 1; end
         6: begin sa = 1; a1 = 1; end
         7: begin rw = 1; rd = 1; end
         8: begin sa = 1; a0 = 1; pwc = 1; ps = 2'b01; end
         9: begin pw = 1; ps = 2'b10; end
         default: ;
      endcase
      return {pw, pwc, io, mr, mw, m2r, irw, rw, rd, sa, sb, ps, a1, a0, ill};
   endfunction

   // Run one instruction: fw fetch wait cycles, mw data-memory wait cycles.
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
      int   ph_q[$];
      logic rdy_q[$];
      logic retires;
      repeat (fw) begin ph_q.push_back(0); rdy_q.push_back(1'b0); end
      ph_q.push_back(0); rdy_q.push_back(1'b1);
      ph_q.push_back(1); rdy_q.push_back(1'($urandom_range(0, 1)));
      if (op == C_LW) begin
         ph_q.push_back(2); rdy_q.push_back(1'($urandom_range(0, 1)));
         repeat (mw) begin ph_q.push_back(3); rdy_q.push_back(1'b0); end
         ph_q.push_back(3); rdy_q.push_back(1'b1);
         ph_q.push_back(4); rdy_q.push_back(1'($urandom_range(0, 1)));
      end else if (op == C_SW) begin
         ph_q.push_back(2); rdy_q.push_back(1'($urandom_range(0, 1)));
         repeat (mw) begin ph_q.push_back(5); rdy_q.push_back(1'b0); end
         ph_q.push_back(5); rdy_q.push_back(1'b1);
      end else if (op == C_R) begin
         ph_q.push_back(6); rdy_q.push_back(1'($urandom_range(0, 1)));
         ph_q.push_back(7); rdy_q.push_back(1'($urandom_range(0, 1)));
      end else if (op == C_BEQ) begin
         ph_q.push_back(8); rdy_q.push_back(1'($urandom_range(0, 1)));
      end else if (op == C_J) begin
         ph_q.push_back(9); rdy_q.push_back(1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < ph_q.size(); i++) begin
         @(negedge clk);
         mem_ready = rdy_q[i];
         // IR contents are arbitrary until the fetch completes
         opcode = (ph_q[i] == 0) ? 6'($urandom) : op;
         #1;
         check_val($sformatf("state op%0h step%0d", op, i), 32'(state),
                   32'(ph_q[i]));
         check_val($sformatf("outs op%0h ph%0d", op, ph_q[i]), 32'(w_act),
                   32'(exp_outs(ph_q[i], rdy_q[i], op)));
         check_val($sformatf("count op%0h step%0d", op, i), instr_count,
                   exp_count);
         retires = (ph_q[i] inside {4, 7, 8, 9}) ||
                   (ph_q[i] == 5 && rdy_q[i]);
         if (retires) exp_count = exp_count + 32'd1;
      end
      // One stalled fetch cycle confirms the return to FETCH and the count
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check_val("back to FETCH", 32'(state), 32'd0);
      check_val("count after instr", instr_count, exp_count);
      check_val("fetch stall outs", 32'(w_act), 32'(exp_outs(0, 1'b0, op)));
   endtask

   function automatic logic [5:0] rand_op();
      logic [5:0] op;
      case ($urandom_range(0, 5))
         0: op = C_LW;
         1: op = C_SW;
         2: op = C_R;
         3: op = C_BEQ;
         4: op = C_J;
         default: begin
            op = 6'($urandom);
            while (is_legal(op)) op = 6'($urandom);
         end
      endcase
      return op;
   endfunction

   initial begin
      reset     = 1'b1;
      mem_ready = 1'b0;
      opcode    = 6'd0;
      exp_count = 32'd0;

      // Reset state
      repeat (2) begin
         @(negedge clk);
         #1;
         check_val("reset state", 32'(state), 32'd0);
         check_val("reset count", instr_count, 32'd0);
         check_val("reset outs", 32'(w_act), 32'(exp_outs(0, 1'b0, 6'd0)));
      end
      @(negedge clk);
      reset = 1'b0;

      // Directed: zero-wait LW, R, SW with 3 stall cycles, BEQ, J, illegal
      run_instr(C_LW, 0, 0);
      run_instr(C_R, 0, 0);
      run_instr(C_SW, 0, 3);
      run_instr(C_BEQ, 0, 0);
      run_instr(C_J, 0, 0);
      run_instr(6'h3F, 0, 0);

      // Randomized instruction stream with random wait states
      for (int n = 0; n < 80; n++) begin
         run_instr(rand_op(), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
      end

      // Reset asserted while stalled in MEMRD aborts without retiring
      @(negedge clk);
      opcode = C_LW; mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check_val("in MEMRD", 32'(state), 32'd3);
      #2;
      reset = 1'b1;
      #1;
      check_val("async reset state", 32'(state), 32'd0);
      check_val("async reset count", instr_count, 32'd0);
      check_val("async reset outs", 32'(w_act), 32'(exp_outs(0, 1'b0, C_LW)));
      @(negedge clk);
      reset = 1'b0;
      exp_count = 32'd0;

      // Counter wrap: preload all-ones, then one J retires
      @(negedge clk);
      force dut.count_q = 32'hFFFF_FFFF;
      #1;
      release dut.count_q;
      #1;
      check_val("preload count", instr_count, 32'hFFFF_FFFF);
      exp_count = 32'hFFFF_FFFF;
      run_instr(C_J, 0, 0);
      check_val("wrapped count", instr_count, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
